// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared types and constants for the buzzer sequencer.
//   width_sel_e  - one-shot length select (short / long)
//   rate_sel_e   - envelope step period select (fast / slow)
//   ENV_LEVEL_MAX - loudest envelope level
//   DEF_*        - default tick counts, in 32768 Hz clk_en ticks
package buzzer_pkg;

    typedef enum logic {
        WIDTH_SHORT = 1'b0,
        WIDTH_LONG  = 1'b1
    } width_sel_e;

    typedef enum logic {
        RATE_FAST = 1'b0,
        RATE_SLOW = 1'b1
    } rate_sel_e;

    localparam logic [2:0] ENV_LEVEL_MAX = 3'd7;

    localparam int DEF_ONE_SHOT_SHORT = 1024;
    localparam int DEF_ONE_SHOT_LONG  = 2048;
    localparam int DEF_ENV_STEP_FAST  = 2048;
    localparam int DEF_ENV_STEP_SLOW  = 4096;

endpackage

// File: rtl/buzzer_one_shot_timer.sv
// buzzer_one_shot_timer: fixed-width one-shot busy timer, counted in clk_en ticks.
//   clk, reset     - system clock, synchronous active-high reset
//   i_clk_en       - 32768 Hz tick
//   i_trigger      - accepted trigger pulse (already qualified by the caller)
//   i_width        - length select, sampled only when a trigger is accepted
//   o_busy         - registered busy flag
//   o_busy_next    - next-state busy, for callers that register derived state
module buzzer_one_shot_timer
    import buzzer_pkg::*;
#(
    parameter int SHORT_TICKS = DEF_ONE_SHOT_SHORT,
    parameter int LONG_TICKS  = DEF_ONE_SHOT_LONG
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clk_en,
    input  logic       i_trigger,
    input  width_sel_e i_width,
    output logic       o_busy,
    output logic       o_busy_next
);

    // The 11-bit counter holds remaining ticks minus one, so a 2048-tick
    // one-shot still fits; busy drops on the tick that finds the count at 0.
    localparam logic [10:0] SHORT_LOAD = 11'(SHORT_TICKS - 1);
    localparam logic [10:0] LONG_LOAD  = 11'(LONG_TICKS - 1);

    logic [10:0] r_count;
    logic [10:0] w_count_next;
    logic        r_busy;
    logic        w_busy_next;

    always_comb begin
        w_count_next = r_count;
        w_busy_next  = r_busy;
        if (i_trigger) begin
            // A retrigger while busy restarts the full width.
            w_count_next = (i_width == WIDTH_LONG) ? LONG_LOAD : SHORT_LOAD;
            w_busy_next  = 1'b1;
        end else if (r_busy && i_clk_en) begin
            if (r_count == 11'd0)
                w_busy_next = 1'b0;
            else
                w_count_next = r_count - 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 11'd0;
            r_busy  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_busy  <= w_busy_next;
        end
    end

    assign o_busy      = r_busy;
    assign o_busy_next = w_busy_next;

endmodule

// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: drives the tone generator enable and a duty gate from the
// CPU sound-control bits (continuous buzz, one-shot buzz, stepped decay envelope).
//   clk, reset            - system clock, synchronous active-high reset
//   i_clk_en              - 32768 Hz tick, one clk wide
//   i_continuous_enable   - buzzer-on level
//   i_one_shot_trigger    - one-clk pulse on CPU write of the one-shot bit
//   i_one_shot_width      - 0 short, 1 long
//   i_envelope_enable     - envelope on level
//   i_envelope_rate       - 0 fast, 1 slow step period
//   i_envelope_reset      - one-clk pulse, restarts the envelope
//   o_buzzer_enabled      - tone generator enable
//   o_one_shot_busy       - one-shot in progress
//   o_envelope_level      - 7 loudest .. 0 quietest
//   o_buzzer_gate         - duty gate, ANDed with the raw tone upstream
module buzzer_sequencer
    import buzzer_pkg::*;
#(
    parameter int ONE_SHOT_SHORT = DEF_ONE_SHOT_SHORT,
    parameter int ONE_SHOT_LONG  = DEF_ONE_SHOT_LONG,
    parameter int ENV_STEP_FAST  = DEF_ENV_STEP_FAST,
    parameter int ENV_STEP_SLOW  = DEF_ENV_STEP_SLOW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clk_en,
    input  logic       i_continuous_enable,
    input  logic       i_one_shot_trigger,
    input  logic       i_one_shot_width,
    input  logic       i_envelope_enable,
    input  logic       i_envelope_rate,
    input  logic       i_envelope_reset,
    output logic       o_buzzer_enabled,
    output logic       o_one_shot_busy,
    output logic [2:0] o_envelope_level,
    output logic       o_buzzer_gate
);

    localparam logic [11:0] FAST_LAST = 12'(ENV_STEP_FAST - 1);
    localparam logic [11:0] SLOW_LAST = 12'(ENV_STEP_SLOW - 1);

    logic        w_accept;
    logic        w_busy;
    logic        w_busy_next;
    logic        w_en_next;
    logic        w_start;
    logic [11:0] w_step_last;
    logic [11:0] r_step;
    logic [11:0] w_step_next;
    logic [2:0]  r_level;
    logic [2:0]  w_level_next;
    logic [3:0]  r_phase;
    logic [3:0]  w_phase_next;
    logic        r_en;
    logic        r_gate;

    // Continuous buzz owns the tone, so one-shot writes are dropped meanwhile.
    assign w_accept = i_one_shot_trigger && !i_continuous_enable;

    buzzer_one_shot_timer #(
        .SHORT_TICKS (ONE_SHOT_SHORT),
        .LONG_TICKS  (ONE_SHOT_LONG)
    ) u_one_shot (
        .clk         (clk),
        .reset       (reset),
        .i_clk_en    (i_clk_en),
        .i_trigger   (w_accept),
        .i_width     (width_sel_e'(i_one_shot_width)),
        .o_busy      (w_busy),
        .o_busy_next (w_busy_next)
    );

    assign w_en_next   = i_continuous_enable || w_busy_next;
    assign w_start     = w_en_next && !r_en;
    // Rate is read live, so a change takes effect on the very next compare.
    assign w_step_last = (rate_sel_e'(i_envelope_rate) == RATE_SLOW) ? SLOW_LAST : FAST_LAST;
    assign w_phase_next = w_start ? 4'd0 : (i_clk_en ? r_phase + 4'd1 : r_phase);

    always_comb begin
        w_step_next  = r_step;
        w_level_next = r_level;
        if (w_start || i_envelope_reset || !i_envelope_enable) begin
            w_step_next  = 12'd0;
            w_level_next = ENV_LEVEL_MAX;
        end else if (r_en && i_clk_en) begin
            // >= rather than == so a counter already past a shortened
            // period steps on the next tick instead of wrapping round.
            if (r_step >= w_step_last) begin
                w_step_next  = 12'd0;
                w_level_next = (r_level == 3'd0) ? 3'd0 : r_level - 3'd1;
            end else begin
                w_step_next = r_step + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_en    <= 1'b0;
            r_step  <= 12'd0;
            r_level <= ENV_LEVEL_MAX;
            r_phase <= 4'd0;
            r_gate  <= 1'b0;
        end else begin
            r_en    <= w_en_next;
            r_step  <= w_step_next;
            r_level <= w_level_next;
            r_phase <= w_phase_next;
            // Built from next-state values so the gate lines up with the
            // registered enable, phase and level; phase <= level gives
            // (level+1)/16 duty.
            r_gate  <= w_en_next && (w_phase_next <= {1'b0, w_level_next});
        end
    end

    assign o_buzzer_enabled = r_en;
    assign o_one_shot_busy  = w_busy;
    assign o_envelope_level = r_level;
    assign o_buzzer_gate    = r_gate;

endmodule
